// File: rtl/imem_fetch_unit.sv
// Parametrised instruction memory with clear sweep, streamed program load
// and a fetch port with stall/flush, placed between the PC and IF/ID.
module imem_fetch_unit #(
    parameter int               ISIZE     = 16,
    parameter int               MEM_SPACE = 8,
    parameter logic [ISIZE-1:0] NOP       = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MEM_SPACE-1:0] address,
    input  logic                 stall,
    input  logic                 PCctrl,
    input  logic                 ld_valid,
    input  logic [ISIZE-1:0]     ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    output logic [MEM_SPACE:0]   ld_count,
    output logic                 run,
    output logic [ISIZE-1:0]     data_out,
    output logic                 valid
);

    localparam int DEPTH = 2 ** MEM_SPACE;
    localparam logic [MEM_SPACE:0] LAST_IDX = (MEM_SPACE + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_LOAD,
        S_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [MEM_SPACE-1:0]   clr_cnt_q;
    logic [MEM_SPACE:0]     ld_count_q;
    logic [ISIZE-1:0]       data_out_q;
    logic                   valid_q;

    logic [ISIZE-1:0]       mem [DEPTH];
    logic                   mem_we;
    logic [MEM_SPACE-1:0]   mem_waddr;
    logic [ISIZE-1:0]       mem_wdata;
    logic                   xfer;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_CLEAR;
        else     state_q <= state_d;
    end

    // Next-state logic: sweep ends at the last index, load ends on last or full
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_CLEAR: if (clr_cnt_q == '1) state_d = S_LOAD;
            S_LOAD:  if (ld_valid && (ld_last || ld_count_q == LAST_IDX)) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_CLEAR;
        endcase
    end

    // Output and write-port decode
    always_comb begin
        ld_ready  = (state_q == S_LOAD);
        run       = (state_q == S_RUN);
        xfer      = ld_ready && ld_valid;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = NOP;
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = NOP;
            end else if (xfer) begin
                mem_we    = 1'b1;
                mem_waddr = ld_count_q[MEM_SPACE-1:0];
                mem_wdata = ld_data;
            end
        end
    end

    // Single synchronous write port; no reset on the array itself
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Counters and the registered fetch output (flush beats stall)
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_q  <= '0;
            ld_count_q <= '0;
            data_out_q <= NOP;
            valid_q    <= 1'b0;
        end else begin
            if (state_q == S_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
            if (xfer)               ld_count_q <= ld_count_q + 1'b1;
            if (state_q == S_RUN) begin
                if (PCctrl) begin
                    data_out_q <= NOP;
                    valid_q    <= 1'b0;
                end else if (!stall) begin
                    data_out_q <= mem[address];
                    valid_q    <= 1'b1;
                end
            end
        end
    end

    assign ld_count = ld_count_q;
    assign data_out = data_out_q;
    assign valid    = valid_q;

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Parametrised instruction memory and fetch stage. Generalises the single-width, file-initialised I-memory.
- Data width, depth and NOP encoding are set by parameters.
- Adds a hardware clear sweep after reset and a streamed program-load port with a valid/ready handshake.
- Adds a fetch interface with stall and flush (PCctrl). Sits between the PC register and the IF/ID pipeline register.

Parameters:
- ISIZE, 16, instruction width in bits.
- MEM_SPACE, 8, address width; DEPTH = 2**MEM_SPACE entries.
- NOP, 0, encoding written during the clear sweep and driven on flush, idle or reset (ISIZE bits).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset: synchronous, active-high.
- address  in  MEM_SPACE  fetch address (PC).
- stall  in  1  hold current data_out/valid.
- PCctrl  in  1  flush: inject NOP instead of fetching.
- ld_valid  in  1  load word present.
- ld_data  in  ISIZE  load word.
- ld_last  in  1  final load word.
- ld_ready  out  1  load port accepting (state LOAD).
- ld_count  out  MEM_SPACE+1  number of words loaded so far.
- run  out  1  state RUN, fetch active.
- data_out  out  ISIZE  fetched instruction.
- valid  out  1  data_out holds a real fetched instruction.

Behaviour:
- FSM states: CLEAR, LOAD, RUN. Memory write and read are synchronous, one port each.
- Reset (rst=1 at posedge), from any state including mid-load or mid-fetch:
  - state <= CLEAR, clear counter <= 0, ld_count <= 0.
  - data_out <= NOP, valid <= 0; ld_ready and run read 0.
  - Memory is not written on a reset edge. While rst is held, the FSM stays in CLEAR with counter 0.
- CLEAR:
  - Each cycle writes NOP to mem[counter], then counter++.
  - The write at counter = DEPTH-1 moves the FSM to LOAD. The sweep takes exactly DEPTH cycles after rst falls.
  - Handshake and fetch inputs are ignored.
- LOAD:
  - ld_ready = 1. A transfer occurs when ld_valid & ld_ready: mem[ld_count] <= ld_data, ld_count++.
  - A transfer with ld_last=1 moves the FSM to RUN.
  - A transfer at ld_count = DEPTH-1 also moves to RUN (implicit last); ld_count then saturates at DEPTH.
  - ld_valid=0 means no write and no change to state.
  - ld_last is ignored without ld_valid.
  - Fetch inputs are ignored; data_out = NOP, valid = 0.
- RUN:
  - ld_ready = 0; ld_valid is ignored.
  - Per posedge, in priority order:
    - PCctrl=1: data_out <= NOP, valid <= 0 (flush wins over stall).
    - else stall=1: data_out and valid hold.
    - else: data_out <= mem[address], valid <= 1.
  - Read latency is 1 cycle: the address presented at edge N appears on data_out after edge N.
  - RUN exits only via rst.
- Widths: ld_count is MEM_SPACE+1 bits so DEPTH is representable. The memory index uses the low MEM_SPACE bits. No other arithmetic.
- Simultaneous events:
  - A load transfer on the same cycle as rst is discarded.
  - PCctrl and stall together act as a flush.
  - ld_last on the DEPTH-1 write is a single transition (no double count).

Test Plan (MEM_SPACE=4, DEPTH=16, ISIZE=16, NOP=0):
- Reset and clear sweep:
  - Stimulus: rst=1 for 2 cycles, then 0.
  - Required: data_out=0, valid=0, ld_ready=0 for 16 cycles; ld_ready=1 on cycle 17.
  - After loading 1 word then last, every read of addresses 1..15 returns 0000.
- Load and fetch:
  - Stimulus: stream 1111, 2222, 3333 (last on 3333) with an ld_valid gap mid-stream.
  - Required: ld_count=3, run=1.
  - address 0,1,2 on consecutive cycles gives data_out 1111, 2222, 3333 one cycle later, valid=1.
- Stall and flush:
  - Stimulus: in RUN with data_out=2222, assert stall 3 cycles while address changes.
  - Required: data_out holds 2222, valid=1.
  - Then PCctrl=1 together with stall=1 gives data_out=0000, valid=0. Next unstalled fetch of addr 2 gives 3333.
- Implicit last:
  - Stimulus: stream 16 words A000..A00F with ld_last=0.
  - Required: run=1 after the 16th transfer, ld_count=16, ld_ready=0.
  - A 17th ld_valid does not modify mem[0] (reads A000).
- Reset mid-operation:
  - Stimulus: rst pulse during LOAD after 2 words, and separately during RUN.
  - Required: next cycle data_out=0, valid=0, run=0, ld_count=0.
  - After the 16-cycle sweep, previously loaded addresses read 0000.
